// File: rtl/q2_mem_arb_pkg.sv
// Shared definitions for the q2 memory bus arbiter: the transaction phase
// encoding and the requester identifiers used for grant and owner.
package q2_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_PNL = 1'b1;

endpackage

// File: rtl/q2_mem_arb_if.sv
// Memory bus between the arbiter and the memory array.
//   mem_addr  : address, stable for the whole transaction
//   mem_wdata : write data, stable for the whole transaction
//   mem_rdata : read data returned by memory
//   wrm / rdm : write / read strobes, never both high
// master = arbiter side, slave = memory side.
interface q2_mem_arb_if #(
    parameter int AW = 12,
    parameter int DW = 12
) ();
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          wrm;
    logic          rdm;

    modport master (
        output mem_addr,
        output mem_wdata,
        output wrm,
        output rdm,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  wrm,
        input  rdm,
        output mem_rdata
    );
endinterface

// File: rtl/q2_mem_arb_prio.sv
// Winner select for the two requesters plus the starvation counter.
//   clk, rst           : clock, synchronous active-high reset
//   run                : 1 = CPU favoured, 0 = panel favoured
//   cpu_req, pnl_req   : raw requests
//   eval               : high while the phase engine is able to grant
//   grant_valid        : at least one requester is asking
//   grant_id           : winner (REQ_CPU / REQ_PNL)
// The counter counts favoured-side wins taken while the other side was
// waiting; once it reaches STARVE_MAX the waiting side gets one turn.
module q2_mem_arb_prio
    import q2_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic cpu_req,
    input  logic pnl_req,
    input  logic eval,
    output logic grant_valid,
    output logic grant_id
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    if (STARVE_MAX < 1) begin : g_chk_starve
        $error("q2_mem_arb_prio: STARVE_MAX must be >= 1");
    end

    logic [CW-1:0] starve_q, starve_d;
    logic          both;
    logic          fav_id;
    logic          at_limit;

    always_comb begin
        both        = cpu_req & pnl_req;
        fav_id      = run ? REQ_CPU : REQ_PNL;
        at_limit    = (starve_q == CW'(STARVE_MAX));
        grant_valid = cpu_req | pnl_req;

        if (both) begin
            grant_id = at_limit ? ~fav_id : fav_id;
        end else begin
            grant_id = pnl_req ? REQ_PNL : REQ_CPU;
        end

        // Any evaluation without contention, or a forced loser grant,
        // clears the count.
        starve_d = starve_q;
        if (eval) begin
            starve_d = (both && !at_limit) ? starve_q + CW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/q2_mem_arb.sv
// Owns the single memory bus and runs one transaction at a time on behalf
// of either the CPU control path or the front panel.
//   clk, rst                 : clock, synchronous active-high reset
//   run                      : 1 = CPU favoured, 0 = panel favoured
//   cpu_req/we/addr/wdata    : CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata       : one-cycle completion, last CPU read data
//   pnl_*                    : same set for the front panel
//   mem                      : memory bus (master side)
//   busy                     : transaction in progress
//   owner                    : current or last grant (0 = CPU, 1 = panel)
//
// state  | meaning
// IDLE   | arbitrate; winner's request is latched at the grant edge
// SETUP  | address/data driven, strobes low (1 cycle)
// STROBE | wrm or rdm asserted (WAIT_CYCLES cycles); read data sampled
//        | at the edge that ends the last cycle
// HOLD   | strobes low, owner's ack pulses (1 cycle), then IDLE
//
// All outputs are registered, so each output reflects the state it is
// paired with in the table above.
module q2_mem_arb
    import q2_mem_arb_pkg::*;
#(
    parameter int AW          = 12,
    parameter int DW          = 12,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          pnl_req,
    input  logic          pnl_we,
    input  logic [AW-1:0] pnl_addr,
    input  logic [DW-1:0] pnl_wdata,
    output logic          pnl_ack,
    output logic [DW-1:0] pnl_rdata,

    q2_mem_arb_if.master  mem,

    output logic          busy,
    output logic          owner
);

    if (WAIT_CYCLES < 1) begin : g_chk_wait
        $error("q2_mem_arb: WAIT_CYCLES must be >= 1");
    end

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e          state_q, state_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            owner_q, owner_d;
    logic            busy_q, busy_d;
    logic            wrm_q, wrm_d;
    logic            rdm_q, rdm_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic            pnl_ack_q, pnl_ack_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]   pnl_rdata_q, pnl_rdata_d;

    logic            grant_valid;
    logic            grant_id;
    logic            eval;

    assign eval = (state_q == IDLE);

    q2_mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .cpu_req     (cpu_req),
        .pnl_req     (pnl_req),
        .eval        (eval),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cpu_rdata_d = cpu_rdata_q;
        pnl_rdata_d = pnl_rdata_q;
        wrm_d       = 1'b0;
        rdm_d       = 1'b0;
        cpu_ack_d   = 1'b0;
        pnl_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = SETUP;
                    owner_d = grant_id;
                    if (grant_id == REQ_PNL) begin
                        we_d    = pnl_we;
                        addr_d  = pnl_addr;
                        wdata_d = pnl_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                wcnt_d  = WCW'(WAIT_CYCLES - 1);
                wrm_d   = we_q;
                rdm_d   = ~we_q;
            end
            STROBE: begin
                if (wcnt_q == '0) begin
                    state_d = HOLD;
                    if (owner_q == REQ_PNL) begin
                        pnl_ack_d = 1'b1;
                        if (!we_q) pnl_rdata_d = mem.mem_rdata;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) cpu_rdata_d = mem.mem_rdata;
                    end
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                    wrm_d  = we_q;
                    rdm_d  = ~we_q;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            wrm_q       <= 1'b0;
            rdm_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            pnl_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            pnl_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            wrm_q       <= wrm_d;
            rdm_q       <= rdm_d;
            cpu_ack_q   <= cpu_ack_d;
            pnl_ack_q   <= pnl_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            pnl_rdata_q <= pnl_rdata_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.wrm       = wrm_q;
    assign mem.rdm       = rdm_q;
    assign cpu_ack       = cpu_ack_q;
    assign pnl_ack       = pnl_ack_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign pnl_rdata     = pnl_rdata_q;
    assign busy          = busy_q;
    assign owner         = owner_q;

endmodule

// File: tb/tb_q2_mem_arb.sv
// Bench for q2_mem_arb: main instance with a 3-cycle strobe and a
// starvation limit of 2, plus a second instance with a 1-cycle strobe.
module tb_q2_mem_arb;

    localparam int W  = 3;
    localparam int SM = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // main instance (W=3)
    logic        run, c_req, c_we, p_req, p_we;
    logic [11:0] c_addr, c_wdata, p_addr, p_wdata;
    logic        c_ack, p_ack, busy, owner;
    logic [11:0] c_rdata, p_rdata;

    // second instance (W=1)
    logic        x_run, xc_req, xc_we, xp_req, xp_we;
    logic [11:0] xc_addr, xc_wdata, xp_addr, xp_wdata;
    logic        xc_ack, xp_ack, x_busy, x_owner;
    logic [11:0] xc_rdata, xp_rdata;

    q2_mem_arb_if #(.AW(12), .DW(12)) mem_a ();
    q2_mem_arb_if #(.AW(12), .DW(12)) mem_b ();

    q2_mem_arb #(.AW(12), .DW(12), .WAIT_CYCLES(W), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .run(run),
        .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
        .cpu_ack(c_ack), .cpu_rdata(c_rdata),
        .pnl_req(p_req), .pnl_we(p_we), .pnl_addr(p_addr), .pnl_wdata(p_wdata),
        .pnl_ack(p_ack), .pnl_rdata(p_rdata),
        .mem(mem_a), .busy(busy), .owner(owner)
    );

    q2_mem_arb #(.AW(12), .DW(12), .WAIT_CYCLES(1), .STARVE_MAX(4)) dut_w1 (
        .clk(clk), .rst(rst), .run(x_run),
        .cpu_req(xc_req), .cpu_we(xc_we), .cpu_addr(xc_addr), .cpu_wdata(xc_wdata),
        .cpu_ack(xc_ack), .cpu_rdata(xc_rdata),
        .pnl_req(xp_req), .pnl_we(xp_we), .pnl_addr(xp_addr), .pnl_wdata(xp_wdata),
        .pnl_ack(xp_ack), .pnl_rdata(xp_rdata),
        .mem(mem_b), .busy(x_busy), .owner(x_owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_starve = 0;
    logic [11:0] m_cpu_rd = 12'h000;
    logic [11:0] m_pnl_rd = 12'h000;

    // One complete transaction on the main instance, starting from an IDLE
    // cycle. The model decides the winner from the arbitration rules and
    // then every cycle of the transaction is compared against the expected
    // timeline (SETUP, W strobe cycles, HOLD, back to IDLE).
    task automatic do_txn(input logic cr, input logic pr, input logic rn,
                          input logic cwe, input logic [11:0] ca, input logic [11:0] cd,
                          input logic pwe, input logic [11:0] pa, input logic [11:0] pd,
                          input logic [11:0] rdv, input bit drop, output logic got_id);
        logic        exp_id, exp_we, fav, stb;
        logic        e_wrm, e_rdm, e_cack, e_pack;
        logic [11:0] exp_a, exp_d;
        c_req = cr; c_we = cwe; c_addr = ca; c_wdata = cd;
        p_req = pr; p_we = pwe; p_addr = pa; p_wdata = pd;
        run   = rn;
        mem_a.mem_rdata = ~rdv;
        got_id = 1'b0;

        fav = rn ? 1'b0 : 1'b1;
        if (cr && pr) begin
            if (m_starve == SM) begin
                exp_id   = ~fav;
                m_starve = 0;
            end else begin
                exp_id   = fav;
                m_starve = m_starve + 1;
            end
        end else begin
            exp_id   = pr;
            m_starve = 0;
        end
        exp_we = exp_id ? pwe : cwe;
        exp_a  = exp_id ? pa : ca;
        exp_d  = exp_id ? pd : cd;

        for (int c = 1; c <= W + 2; c++) begin
            @(posedge clk); #1;
            if (c == 1) got_id = owner;
            if (c == 1 && drop) begin
                if (exp_id) p_req = 1'b0; else c_req = 1'b0;
            end
            stb    = (c >= 2) && (c <= W + 1);
            e_wrm  = stb & exp_we;
            e_rdm  = stb & ~exp_we;
            e_cack = (c == W + 2) && (exp_id == 1'b0);
            e_pack = (c == W + 2) && (exp_id == 1'b1);
            if (c == W + 2 && !exp_we) begin
                if (exp_id) m_pnl_rd = rdv; else m_cpu_rd = rdv;
            end

            n_checks++;
            if (busy !== 1'b1 || owner !== exp_id || mem_a.mem_addr !== exp_a || mem_a.mem_wdata !== exp_d) begin
                n_fail++;
                $display("FAIL txn_bus c=%0d: busy=%b owner=%b addr=%h wdata=%h, expected busy=1 owner=%b addr=%h wdata=%h",
                         c, busy, owner, mem_a.mem_addr, mem_a.mem_wdata, exp_id, exp_a, exp_d);
            end
            n_checks++;
            if (mem_a.wrm !== e_wrm || mem_a.rdm !== e_rdm) begin
                n_fail++;
                $display("FAIL txn_strobe c=%0d: wrm=%b rdm=%b, expected wrm=%b rdm=%b",
                         c, mem_a.wrm, mem_a.rdm, e_wrm, e_rdm);
            end
            n_checks++;
            if (c_ack !== e_cack || p_ack !== e_pack) begin
                n_fail++;
                $display("FAIL txn_ack c=%0d: cpu_ack=%b pnl_ack=%b, expected %b %b",
                         c, c_ack, p_ack, e_cack, e_pack);
            end
            n_checks++;
            if (c_rdata !== m_cpu_rd || p_rdata !== m_pnl_rd) begin
                n_fail++;
                $display("FAIL txn_rdata c=%0d: cpu_rdata=%h pnl_rdata=%h, expected %h %h",
                         c, c_rdata, p_rdata, m_cpu_rd, m_pnl_rd);
            end

            // memory only presents the real word in the final strobe cycle
            mem_a.mem_rdata = (c == W + 1) ? rdv : ~rdv;
            // requester drops its request after seeing ack
            if (c == W + 2) begin
                if (exp_id) p_req = 1'b0; else c_req = 1'b0;
            end
        end

        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || c_ack !== 1'b0 || p_ack !== 1'b0 || mem_a.wrm !== 1'b0 || mem_a.rdm !== 1'b0) begin
            n_fail++;
            $display("FAIL txn_end: busy=%b cpu_ack=%b pnl_ack=%b wrm=%b rdm=%b, expected all 0",
                     busy, c_ack, p_ack, mem_a.wrm, mem_a.rdm);
        end
    endtask

    task automatic idle_cycles(input int n);
        c_req = 1'b0;
        p_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            m_starve = 0;
            n_checks++;
            if (busy !== 1'b0 || c_ack !== 1'b0 || p_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL idle: busy=%b cpu_ack=%b pnl_ack=%b, expected 0 0 0", busy, c_ack, p_ack);
            end
        end
    endtask

    task automatic test_reset();
        logic g;
        rst = 1'b1;
        c_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({c_ack, p_ack, busy, owner, mem_a.wrm, mem_a.rdm} !== 6'b0 ||
                c_rdata !== 12'h0 || p_rdata !== 12'h0 ||
                mem_a.mem_addr !== 12'h0 || mem_a.mem_wdata !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: ack=%b%b busy=%b owner=%b wrm=%b rdm=%b rd=%h/%h addr=%h wd=%h, expected all 0",
                         c_ack, p_ack, busy, owner, mem_a.wrm, mem_a.rdm, c_rdata, p_rdata,
                         mem_a.mem_addr, mem_a.mem_wdata);
            end
            n_checks++;
            if ({xc_ack, xp_ack, x_busy, x_owner, mem_b.wrm, mem_b.rdm} !== 6'b0 || xc_rdata !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_outputs_w1: ack=%b%b busy=%b owner=%b wrm=%b rdm=%b, expected all 0",
                         xc_ack, xp_ack, x_busy, x_owner, mem_b.wrm, mem_b.rdm);
            end
        end
        rst = 1'b0;
        m_starve = 0;
        m_cpu_rd = 12'h000;
        m_pnl_rd = 12'h000;
        // grant must happen at the very first edge after release
        do_txn(1'b1, 1'b0, 1'b1, 1'b0, 12'h055, 12'h0AA, 1'b0, 12'h0, 12'h0, 12'h321, 1'b0, g);
    endtask

    task automatic test_cpu_read_w1();
        xc_req = 1'b1; xc_we = 1'b0; xc_addr = 12'h123; xc_wdata = 12'h000;
        mem_b.mem_rdata = 12'hABC;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (mem_b.wrm !== 1'b0 || mem_b.rdm !== (c == 2) || xc_ack !== (c == 3) || xp_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL w1_read_strobes c=%0d: wrm=%b rdm=%b cpu_ack=%b pnl_ack=%b", c,
                         mem_b.wrm, mem_b.rdm, xc_ack, xp_ack);
            end
            n_checks++;
            if (x_busy !== (c <= 3)) begin
                n_fail++;
                $display("FAIL w1_read_busy c=%0d: busy=%b, expected %b", c, x_busy, (c <= 3));
            end
            if (c <= 3) begin
                n_checks++;
                if (mem_b.mem_addr !== 12'h123) begin
                    n_fail++;
                    $display("FAIL w1_read_addr c=%0d: addr=%h, expected 123", c, mem_b.mem_addr);
                end
            end
            if (c >= 3) begin
                n_checks++;
                if (xc_rdata !== 12'hABC) begin
                    n_fail++;
                    $display("FAIL w1_read_rdata c=%0d: cpu_rdata=%h, expected abc", c, xc_rdata);
                end
            end
            if (c == 3) begin
                xc_req = 1'b0;
                mem_b.mem_rdata = 12'h5E5;
            end
        end
    endtask

    task automatic test_pnl_write();
        logic g;
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 1'b1, 12'h7FF, 12'h5A5, 12'h111, 1'b0, g);
    endtask

    task automatic test_contention();
        logic g;
        logic exp_run1 [6];
        logic exp_run0 [6];
        exp_run1 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_run0 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        idle_cycles(1);
        for (int i = 0; i < 6; i++) begin
            do_txn(1'b1, 1'b1, 1'b1, 1'b1, 12'h100 + 12'(i), 12'h200 + 12'(i),
                   1'b0, 12'h300 + 12'(i), 12'h0, 12'h400 + 12'(i), 1'b0, g);
            n_checks++;
            if (g !== exp_run1[i]) begin
                n_fail++;
                $display("FAIL contention_run1 #%0d: owner=%b, expected %b", i, g, exp_run1[i]);
            end
        end
        idle_cycles(1);
        for (int i = 0; i < 6; i++) begin
            do_txn(1'b1, 1'b1, 1'b0, 1'b0, 12'h500 + 12'(i), 12'h0,
                   1'b1, 12'h600 + 12'(i), 12'h700 + 12'(i), 12'h800 + 12'(i), 1'b0, g);
            n_checks++;
            if (g !== exp_run0[i]) begin
                n_fail++;
                $display("FAIL contention_run0 #%0d: owner=%b, expected %b", i, g, exp_run0[i]);
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        logic g;
        c_req = 1'b0;
        p_req = 1'b1; p_we = 1'b1; p_addr = 12'h2A5; p_wdata = 12'h0F0;
        run = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (mem_a.wrm !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: wrm=%b busy=%b, expected 1 1", mem_a.wrm, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (mem_a.wrm !== 1'b0 || busy !== 1'b0 || p_ack !== 1'b0 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abort: wrm=%b busy=%b pnl_ack=%b owner=%b, expected 0 0 0 0",
                     mem_a.wrm, busy, p_ack, owner);
        end
        rst = 1'b0;
        m_starve = 0;
        m_cpu_rd = 12'h000;
        m_pnl_rd = 12'h000;
        idle_cycles(6);
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 12'h2A5, 12'h0, 12'h3C3, 1'b0, g);
    endtask

    task automatic test_drop_in_setup();
        logic g;
        do_txn(1'b1, 1'b0, 1'b1, 1'b0, 12'h456, 12'h0, 1'b0, 12'h0, 12'h0, 12'h9D2, 1'b1, g);
        idle_cycles(5);
    endtask

    task automatic test_random();
        logic        g;
        logic [1:0]  sel;
        for (int i = 0; i < 24; i++) begin
            sel = 2'($urandom_range(1, 3));
            do_txn(sel[0], sel[1], 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom),
                   1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom),
                   12'($urandom), 1'($urandom_range(0, 3) == 0), g);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        x_run = 1'b1;
        xc_req = 1'b0; xc_we = 1'b0; xc_addr = '0; xc_wdata = '0;
        xp_req = 1'b0; xp_we = 1'b0; xp_addr = '0; xp_wdata = '0;
        mem_a.mem_rdata = '0;
        mem_b.mem_rdata = '0;

        test_reset();
        test_cpu_read_w1();
        test_pnl_write();
        test_contention();
        test_reset_mid_strobe();
        test_drop_in_setup();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/q2_mem_arb.md
Name: q2_mem_arb

Overview:
- Sequences the single 12-bit memory bus (address, data, wrm, rdm) and shares it between two requesters: the CPU control path and the front-panel examine/deposit logic.
- Replaces direct strobe driving with one owned transaction engine that has fixed setup, strobe and hold phases.
- Priority follows the run flag. A starvation guard ensures neither side is locked out.

Parameters:
- AW, 12, address width
- DW, 12, data width
- WAIT_CYCLES, 1, strobe-phase length in clocks; must be >=1, and 0 is rejected at elaboration
- STARVE_MAX, 4, consecutive grants to the favoured side before a waiting loser is forced in; must be >=1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- run  in  1  CPU running; 1 = CPU favoured, 0 = panel favoured
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data; valid in the ack cycle and held until the next CPU read completes
- pnl_req, pnl_we, pnl_addr, pnl_wdata, pnl_ack, pnl_rdata  same as the cpu_* ports, for the front panel
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- wrm  out  1  memory write strobe
- rdm  out  1  memory read strobe
- busy  out  1  transaction in progress (any state except IDLE)
- owner  out  1  current or last grant; 0 = CPU, 1 = panel

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0.
- Reset is sampled every edge. Asserting it mid-transaction aborts the transaction: strobes drop and state returns to IDLE at that edge, and no ack is issued.
- States and transitions:
  - IDLE: arbitrate.
  - SETUP: exactly 1 cycle.
  - STROBE: exactly WAIT_CYCLES cycles.
  - HOLD: exactly 1 cycle, then IDLE unconditionally.
- Arbitration happens only in IDLE.
  - Only one requester active: that one is granted.
  - Both active: the favoured side (CPU if run=1, panel if run=0) wins, unless the starvation counter equals STARVE_MAX, in which case the other side wins and the counter clears.
  - The counter increments on each favoured-side grant made while the other side was also requesting. It clears when the other side is granted or is not requesting at an IDLE evaluation.
  - A change in run affects only the next IDLE evaluation.
- Grant latching: at the grant edge, the winner's we, addr and wdata are latched into internal registers. mem_addr and mem_wdata are driven from these registers and held stable through SETUP, STROBE and HOLD.
- Strobes: in STROBE only, wrm=we and rdm=~we. Strobes are 0 in every other state and never both 1.
- Read capture: mem_rdata is captured at the edge ending the last STROBE cycle into the owner's rdata register. The other requester's rdata is unchanged.
- Ack: the owner's ack is 1 for the single HOLD cycle. Each transaction produces exactly one ack.
- Request deassertion: if the owner drops req after grant, the transaction still completes and ack still pulses.
- Latency: grant edge at cycle 0, then SETUP at cycle 1, STROBE at cycles 2..1+W, HOLD/ack at cycle 2+W. Minimum period between back-to-back transactions is W+3 cycles.
- Requester contract: req is registered by the requester and dropped the cycle after ack, so the following IDLE cycle sees it low. No re-grant happens without a fresh request.
- Write data width is fixed at DW. No partial writes. Address is not incremented; auto-increment belongs to the panel logic.
- busy = (state != IDLE). owner updates only at grant.

Decomposition:
- q2_pkg holds:
  - state encoding: IDLE, SETUP, STROBE, HOLD
  - requester ids: REQ_CPU=0, REQ_PNL=1
- Sub-module q2_mem_arb_prio: combinational winner select plus the registered starvation counter.
  - Inputs: clk, rst, run, cpu_req, pnl_req, eval strobe.
  - Outputs: grant_valid, grant_id.
- The top level holds the phase FSM, the WAIT_CYCLES strobe counter, the latched request registers and the rdata registers.

Test Plan:
- Reset: hold rst 2 cycles with cpu_req=1 -> all outputs 0, no strobe. After release, a grant occurs at the first IDLE edge.
- CPU read, W=1: addr=0x123, mem_rdata=0xABC -> rdm high only on cycle 2, cpu_ack on cycle 3, cpu_rdata=0xABC thereafter, wrm never high.
- Panel write, run=0, W=3: addr=0x7FF, wdata=0x5A5 -> wrm high cycles 2-4, mem_addr/mem_wdata stable cycles 1-5, pnl_ack on cycle 5, pnl_rdata unchanged.
- Contention, run=1, both requesting continuously, STARVE_MAX=2 -> grant order CPU, CPU, PNL, CPU, CPU, PNL. With run=0 the order is PNL, PNL, CPU, ...
- Reset mid-STROBE (W=3, assert rst on cycle 3) -> wrm=0 and busy=0 after that edge, no ack ever issued, next request completes normally.
- Owner drops req during SETUP -> transaction completes, a single ack pulses in HOLD, and no second transaction starts.
